// File: rtl/median_sort_scheduler_pkg.sv
// Shared types and helpers for the median sort scheduler: pixel and window
// types, FSM state encodings and window slice access.
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif

// Bit range of pixel k inside a packed window, for use as w[`WIN_SLICE(k)].
`ifndef WIN_SLICE
`define WIN_SLICE(k) ((k) * `BIT_WIDTH) +: `BIT_WIDTH
`endif

package median_sort_scheduler_pkg;

    localparam int BIT_WIDTH = `BIT_WIDTH;

    // A window is 3x3 pixels in raster order; pixel 4 is the centre.
    localparam int          WIN_PIX    = 9;
    localparam int unsigned CENTRE_IDX = 4;

    typedef logic [BIT_WIDTH-1:0]         pix_t;
    typedef logic [WIN_PIX*BIT_WIDTH-1:0] win_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

    // Pixel k of a packed window.
    function automatic pix_t win_slice(input win_t w, input int unsigned k);
        return w[k*BIT_WIDTH +: BIT_WIDTH];
    endfunction

endpackage

// File: rtl/median_sort_scheduler_if.sv
// Bundle of the window input, sort unit and median output handshakes.
// master = scheduler side, slave = the surrounding blocks.
interface median_sort_scheduler_if;
    import median_sort_scheduler_pkg::*;

    // Upstream window stream
    logic win_valid_i;
    logic win_ready_o;
    win_t win_data_i;

    // Shared bubble sort unit
    logic sort_start_o;
    win_t sort_win_o;
    logic sort_valid_i;
    pix_t sort_median_i;

    // Downstream pixel stream
    logic med_valid_o;
    logic med_ready_i;
    pix_t med_data_o;
    logic med_last_o;

    // Status
    logic busy_o;
    logic timeout_err_o;

    modport master (
        input  win_valid_i,
        input  win_data_i,
        input  sort_valid_i,
        input  sort_median_i,
        input  med_ready_i,
        output win_ready_o,
        output sort_start_o,
        output sort_win_o,
        output med_valid_o,
        output med_data_o,
        output med_last_o,
        output busy_o,
        output timeout_err_o
    );

    modport slave (
        output win_valid_i,
        output win_data_i,
        output sort_valid_i,
        output sort_median_i,
        output med_ready_i,
        input  win_ready_o,
        input  sort_start_o,
        input  sort_win_o,
        input  med_valid_o,
        input  med_data_o,
        input  med_last_o,
        input  busy_o,
        input  timeout_err_o
    );

endinterface

// File: rtl/median_pos_counter.sv
// Raster position tracker: column/row counters that wrap at the image edge,
// plus flags for "window sits on the image border" and "last pixel of frame".
module median_pos_counter #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic clk,
    input  logic srst,
    input  logic advance_i,
    output logic border_o,
    output logic last_o
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Position registers; frame starts at the top-left pixel.
    always_ff @(posedge clk) begin
        if (srst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Step one pixel in raster order; the frame wraps with no gap.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (advance_i) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    assign border_o = (row_q == '0) || (row_q == ROW_MAX) ||
                      (col_q == '0) || (col_q == COL_MAX);
    assign last_o   = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/median_sort_scheduler.sv
// Drives one shared 9-input sort unit to turn a stream of 3x3 windows into a
// stream of median pixels. Border windows bypass the sort with their centre
// pixel; a watchdog falls back to the centre pixel if the sort never answers.
module median_sort_scheduler
    import median_sort_scheduler_pkg::*;
#(
    parameter int IMG_W        = 128,
    parameter int IMG_H        = 128,
    parameter int SORT_TIMEOUT = 63
) (
    input  logic CLK,
    input  logic RST,
    median_sort_scheduler_if.master bus
);

    // The watchdog counts up to SORT_TIMEOUT, so size it to hold that value.
    localparam int WD_W = $clog2(SORT_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(SORT_TIMEOUT - 1);

    state_t          state_q, state_d;
    win_t            win_q, win_d;
    pix_t            med_q, med_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            tmo_q, tmo_d;   // current window ended by the watchdog
    logic            err_q, err_d;   // sticky: any watchdog expiry since reset
    logic            advance;
    logic            border;
    logic            last_pix;
    pix_t            centre;

    assign centre = win_slice(win_q, CENTRE_IDX);

    median_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .clk       (CLK),
        .srst      (RST),
        .advance_i (advance),
        .border_o  (border),
        .last_o    (last_pix)
    );

    // State and datapath registers; reset abandons any window in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            med_q   <= '0;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            med_q   <= med_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept, classify, sort or bypass, then present.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        med_d   = med_q;
        wd_d    = wd_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // win_ready_o is high in IDLE, so valid alone completes the handshake.
                if (bus.win_valid_i) begin
                    win_d   = bus.win_data_i;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (border) begin
                    med_d   = centre;
                    state_d = ST_OUT;
                end else begin
                    wd_d    = '0;
                    tmo_d   = 1'b0;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                wd_d = wd_q + WD_W'(1);
                // A sort result arriving on the watchdog's final cycle still wins.
                if (bus.sort_valid_i) begin
                    med_d   = bus.sort_median_i;
                    state_d = ST_RELEASE;
                end else if (wd_q == WD_LAST) begin
                    med_d   = centre;
                    tmo_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // Wait for the sort unit to leave DONE so it can be restarted;
                // a timed-out sort is not waited on.
                if (tmo_q || !bus.sort_valid_i) begin
                    state_d = ST_OUT;
                end
            end

            ST_OUT: begin
                if (bus.med_ready_i) begin
                    advance = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.win_ready_o   = (state_q == ST_IDLE) && !RST;
    assign bus.sort_start_o  = (state_q == ST_START);
    assign bus.sort_win_o    = win_q;
    assign bus.med_valid_o   = (state_q == ST_OUT);
    assign bus.med_data_o    = med_q;
    assign bus.med_last_o    = (state_q == ST_OUT) && last_pix;
    assign bus.busy_o        = (state_q != ST_IDLE);
    assign bus.timeout_err_o = err_q;

endmodule

// File: tb/tb_median_sort_scheduler.sv
// Bench for median_sort_scheduler on a 4x4 image with a behavioural sort unit.
module tb_median_sort_scheduler;
    import median_sort_scheduler_pkg::*;

    localparam int W        = 4;
    localparam int H        = 4;
    localparam int TMO      = 63;
    localparam int SORT_LAT = 36;

    typedef struct {
        pix_t med;
        logic last;
        logic bypass;
    } exp_t;

    typedef struct {
        win_t win;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    median_sort_scheduler_if bus();

    median_sort_scheduler #(
        .IMG_W        (W),
        .IMG_H        (H),
        .SORT_TIMEOUT (TMO)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int   vectors = 0;
    int   errors  = 0;
    int   ntx     = 0;
    exp_t sb[$];
    int   pr = 0;
    int   pc = 0;
    int   seed = 1;
    vec_t tbl[16];

    // ---------------- behavioural sort unit ----------------
    bit   never_valid = 1'b0;
    int   hold_extra  = 0;
    logic sm_busy     = 1'b0;
    int   sm_cnt      = 0;
    int   hold_cnt    = 0;

    function automatic pix_t centre_of(input win_t w);
        return w[4*BIT_WIDTH +: BIT_WIDTH];
    endfunction

    function automatic pix_t true_median(input win_t w);
        pix_t a[9];
        pix_t t;
        for (int k = 0; k < 9; k++) a[k] = w[k*BIT_WIDTH +: BIT_WIDTH];
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0; j--)
                if (a[j-1] > a[j]) begin
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                end
        return a[4];
    endfunction

    function automatic win_t gen_win(input int s);
        win_t w;
        for (int k = 0; k < 9; k++)
            w[k*BIT_WIDTH +: BIT_WIDTH] = pix_t'((s * 29 + k * 71 + 13) % 251);
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            sm_busy           <= 1'b0;
            sm_cnt            <= 0;
            hold_cnt          <= 0;
            bus.sort_valid_i  <= 1'b0;
            bus.sort_median_i <= '0;
        end else if (!sm_busy && !bus.sort_valid_i) begin
            if (bus.sort_start_o) begin
                sm_busy           <= 1'b1;
                sm_cnt            <= 1;
                bus.sort_median_i <= true_median(bus.sort_win_o);
            end
        end else if (sm_busy) begin
            if (!bus.sort_start_o) begin
                sm_busy <= 1'b0;
            end else if (!never_valid) begin
                if (sm_cnt == SORT_LAT) begin
                    bus.sort_valid_i <= 1'b1;
                    sm_busy          <= 1'b0;
                    hold_cnt         <= 0;
                end else begin
                    sm_cnt <= sm_cnt + 1;
                end
            end
        end else if (!bus.sort_start_o) begin
            if (hold_cnt == hold_extra) bus.sort_valid_i <= 1'b0;
            else                        hold_cnt <= hold_cnt + 1;
        end
    end

    // Count sort starts (rising edges of sort_start_o).
    int   starts     = 0;
    logic start_prev = 1'b0;
    always @(negedge clk) begin
        start_prev <= bus.sort_start_o;
        if (bus.sort_start_o && !start_prev) starts <= starts + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic bit on_border(input int r, input int c);
        return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    endfunction

    task automatic advance_pos();
        if (pc == W - 1) begin
            pc = 0;
            pr = (pr == H - 1) ? 0 : pr + 1;
        end else begin
            pc = pc + 1;
        end
    endtask

    // Present a window at a negedge; returns at the negedge after acceptance.
    task automatic send(input win_t w, input exp_t e);
        int n;
        n = 0;
        bus.win_valid_i = 1'b1;
        bus.win_data_i  = w;
        while (!bus.win_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.win_ready_o) begin
            errors++;
            vectors++;
            $display("FAIL accept: win_ready_o never rose, got 0, want 1");
        end
        sb.push_back(e);
        @(negedge clk);
        bus.win_valid_i = 1'b0;
    endtask

    // Wait for med_valid_o; lat counts cycles from the accept edge.
    task automatic wait_valid(output int lat, output int nstart);
        lat    = 1;
        nstart = 0;
        while (!bus.med_valid_o && lat < 400) begin
            if (bus.sort_start_o) nstart++;
            @(negedge clk);
            lat++;
        end
        check("med_valid_o arrives", 32'(bus.med_valid_o), 32'd1);
    endtask

    task automatic run_vec(input win_t w, input exp_t e, input string nm);
        int   s0, lat, ns;
        exp_t got;
        s0 = starts;
        send(w, e);
        wait_valid(lat, ns);
        got = (sb.size() > 0) ? sb.pop_front() : e;
        ntx++;
        $display("txn %0d %s pos(%0d,%0d): med=%0d last=%0d lat=%0d", ntx, nm, pr, pc,
                 bus.med_data_o, bus.med_last_o, lat);
        check({nm, " med_data_o"}, 32'(bus.med_data_o), 32'(got.med));
        check({nm, " med_last_o"}, 32'(bus.med_last_o), 32'(got.last));
        check({nm, " sort starts"}, 32'(starts - s0), got.bypass ? 32'd0 : 32'd1);
        if (got.bypass) check({nm, " bypass latency"}, 32'(lat), 32'd2);
        @(negedge clk);
        advance_pos();
    endtask

    task automatic run_auto(input string nm);
        win_t w;
        exp_t e;
        w        = gen_win(seed);
        seed     = seed + 1;
        e.bypass = on_border(pr, pc);
        e.last   = (pr == H - 1) && (pc == W - 1);
        e.med    = e.bypass ? centre_of(w) : true_median(w);
        run_vec(w, e, nm);
    endtask

    task automatic goto_interior();
        while (on_border(pr, pc)) run_auto("filler");
    endtask

    // ---------------- test sequence ----------------
    initial begin
        win_t w;
        exp_t e;
        exp_t got;
        int   lat, ns, s0, extra;

        bus.win_valid_i = 1'b0;
        bus.win_data_i  = '0;
        bus.med_ready_i = 1'b1;
        rst             = 1'b1;

        // Stimulus table: one full 4x4 frame.
        for (int i = 0; i < 16; i++) begin
            if (i == 0)
                w = {8'd80, 8'd70, 8'd60, 8'd50, 8'd4, 8'd40, 8'd30, 8'd20, 8'd10};
            else if (i == 5)
                w = {8'd5, 8'd4, 8'd6, 8'd3, 8'd7, 8'd2, 8'd8, 8'd1, 8'd9};
            else
                w = gen_win(1000 + i);
            tbl[i].win      = w;
            tbl[i].e.bypass = on_border(i / W, i % W);
            tbl[i].e.med    = tbl[i].e.bypass ? centre_of(w) : true_median(w);
            tbl[i].e.last   = (i == 15);
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check("win_ready_o in reset", 32'(bus.win_ready_o), 32'd0);
        rst = 1'b0;
        #1;
        check("reset win_ready_o", 32'(bus.win_ready_o), 32'd1);
        check("reset sort_start_o", 32'(bus.sort_start_o), 32'd0);
        check("reset sort_win_o", 32'(bus.sort_win_o != '0), 32'd0);
        check("reset med_valid_o", 32'(bus.med_valid_o), 32'd0);
        check("reset med_data_o", 32'(bus.med_data_o), 32'd0);
        check("reset med_last_o", 32'(bus.med_last_o), 32'd0);
        check("reset busy_o", 32'(bus.busy_o), 32'd0);
        check("reset timeout_err_o", 32'(bus.timeout_err_o), 32'd0);
        @(negedge clk);

        // Two back-to-back frames from the table.
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++)
                run_vec(tbl[i].win, tbl[i].e, $sformatf("frame%0d win%0d", f, i));

        // Backpressure on an interior result.
        goto_interior();
        w = gen_win(seed); seed++;
        e.bypass = 1'b0; e.last = 1'b0; e.med = true_median(w);
        bus.med_ready_i = 1'b0;
        send(w, e);
        wait_valid(lat, ns);
        got = (sb.size() > 0) ? sb.pop_front() : e;
        ntx++;
        $display("txn %0d backpressure: med=%0d", ntx, bus.med_data_o);
        check("bp med_data_o", 32'(bus.med_data_o), 32'(got.med));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp med_valid_o held", 32'(bus.med_valid_o), 32'd1);
            check("bp med_data_o held", 32'(bus.med_data_o), 32'(got.med));
            check("bp med_last_o held", 32'(bus.med_last_o), 32'(got.last));
            check("bp win_ready_o low", 32'(bus.win_ready_o), 32'd0);
        end
        bus.med_ready_i = 1'b1;
        @(negedge clk);
        check("bp released", 32'(bus.med_valid_o), 32'd0);
        advance_pos();

        // Watchdog timeout: the sort never answers.
        goto_interior();
        never_valid = 1'b1;
        w = gen_win(seed); seed++;
        e.bypass = 1'b0; e.last = 1'b0; e.med = centre_of(w);
        send(w, e);
        wait_valid(lat, ns);
        got = (sb.size() > 0) ? sb.pop_front() : e;
        ntx++;
        $display("txn %0d timeout: med=%0d start_cycles=%0d", ntx, bus.med_data_o, ns);
        check("timeout med_data_o", 32'(bus.med_data_o), 32'(got.med));
        check("timeout START cycles", 32'(ns), 32'(TMO));
        check("timeout_err_o set", 32'(bus.timeout_err_o), 32'd1);
        @(negedge clk);
        advance_pos();
        never_valid = 1'b0;
        goto_interior();
        run_auto("after timeout");
        check("timeout_err_o sticky", 32'(bus.timeout_err_o), 32'd1);

        // Sort valid lingering after start drops.
        goto_interior();
        hold_extra = 3;
        w = gen_win(seed); seed++;
        e.bypass = 1'b0; e.last = 1'b0; e.med = true_median(w);
        send(w, e);
        wait_valid(lat, ns);
        got = (sb.size() > 0) ? sb.pop_front() : e;
        ntx++;
        $display("txn %0d sticky valid: med=%0d lat=%0d", ntx, bus.med_data_o, lat);
        check("sticky sort_valid_i low at output", 32'(bus.sort_valid_i), 32'd0);
        check("sticky med_data_o", 32'(bus.med_data_o), 32'(got.med));
        @(negedge clk);
        advance_pos();
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.med_valid_o) extra++;
            @(negedge clk);
        end
        check("sticky no double output", 32'(extra), 32'd0);
        hold_extra = 0;

        // Reset while the sort is running.
        goto_interior();
        w = gen_win(seed); seed++;
        e.bypass = 1'b0; e.last = 1'b0; e.med = true_median(w);
        send(w, e);
        s0 = 0;
        while (!bus.sort_start_o && s0 < 20) begin
            @(negedge clk);
            s0++;
        end
        check("mid-sort start seen", 32'(bus.sort_start_o), 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst win_ready_o", 32'(bus.win_ready_o), 32'd0);
        check("rst sort_start_o", 32'(bus.sort_start_o), 32'd0);
        check("rst sort_win_o", 32'(bus.sort_win_o != '0), 32'd0);
        check("rst med_valid_o", 32'(bus.med_valid_o), 32'd0);
        check("rst med_data_o", 32'(bus.med_data_o), 32'd0);
        check("rst busy_o", 32'(bus.busy_o), 32'd0);
        check("rst timeout_err_o", 32'(bus.timeout_err_o), 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst win_ready_o", 32'(bus.win_ready_o), 32'd1);
        sb.delete();
        pr = 0;
        pc = 0;
        run_auto("post-rst (0,0)");
        goto_interior();
        run_auto("post-rst interior");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global time limit: got expired, want finished");
        $fatal(1, "time limit");
    end

endmodule
